data_mem_arbiter: RTL and testbench

Two-port arbiter and access sequencer that shares the single-port 32-word `Data_Memory` between the CPU load/store path (port 0) and a debug/loader port (port 1). It sits between the requesters and the memory, which has an asynchronous read and a synchronous write. It applies round-robin priority and latches the winning request. It then runs a fixed three-state access sequence (IDLE → ACCESS → RESP) and returns read data with a one-cycle `done` pulse.

---
 rtl/data_mem_arbiter.sv | 121 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin two-port arbiter and IDLE/ACCESS/RESP sequencer for Data_Memory
module data_mem_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_winner_q, last_winner_d;
    logic                win_q, win_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                any_req;
    logic                arb_win;

    // A tie goes to the port that did not win last time; otherwise the lone requester wins.
    always_comb begin
        any_req = req0 | req1;
        arb_win = (req0 & req1) ? ~last_winner_q : req1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (any_req) state_d = S_ACCESS;
            S_ACCESS: state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner_q <= 1'b1;
            win_q         <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
        end else begin
            last_winner_q <= last_winner_d;
            win_q         <= win_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
        end
    end

    // Request fields are captured once on the grant; the memory bus keeps showing them afterwards.
    always_comb begin
        last_winner_d = last_winner_q;
        win_d         = win_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        if (state_q == S_IDLE && any_req) begin
            last_winner_d = arb_win;
            win_d         = arb_win;
            we_d          = arb_win ? we1    : we0;
            addr_d        = arb_win ? addr1  : addr0;
            wdata_d       = arb_win ? wdata1 : wdata0;
        end
        if (state_q == S_ACCESS && !we_q) begin
            rdata_d = mem_rdata;
        end
    end

    always_comb begin
        gnt0      = (state_q == S_ACCESS) && !win_q;
        gnt1      = (state_q == S_ACCESS) &&  win_q;
        done0     = (state_q == S_RESP)   && !win_q;
        done1     = (state_q == S_RESP)   &&  win_q;
        busy      = (state_q != S_IDLE);
        mem_we    = (state_q == S_ACCESS) && we_q && !reset;
        mem_re    = (state_q == S_ACCESS) && !we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        rdata     = rdata_q;
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - randomized directed bench for data_mem_arbiter against a transaction-level model
module tb_data_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [4:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        gnt0, gnt1, done0, done1, busy, mem_we, mem_re;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [4:0]  mem_addr;

    int checks = 0;
    int failures = 0;

    // Environment memory: initial contents in init_mem, DUT writes tracked separately.
    logic [31:0] init_mem  [32];
    logic [31:0] wr_mem    [32];
    logic        written   [32];
    int          we_cnt = 0;

    // Reference model state.
    logic [31:0] ref_mem   [32];
    logic [31:0] exp_rdata;
    bit          lw;

    always #5 clk = ~clk;

    data_mem_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .busy(busy), .mem_we(mem_we), .mem_re(mem_re),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] env_word(input logic [4:0] a);
        return written[a] ? wr_mem[a] : init_mem[a];
    endfunction

    assign mem_rdata = env_word(mem_addr);

    always @(posedge clk) begin
        if (mem_we) begin
            wr_mem[mem_addr]  <= mem_wdata;
            written[mem_addr] <= 1'b1;
            we_cnt            <= we_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] rnd_addr();
        logic [4:0] a;
        a = 5'($urandom_range(0, 31));
        if (a == 5'd7) a = 5'd8;
        return a;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req0 = 0; req1 = 0;
        @(negedge clk);
        @(negedge clk);
        lw = 1'b1;
        exp_rdata = '0;
        reset = 1'b0;
    endtask

    task automatic drive(input bit p, input bit r, input bit w, input logic [4:0] a, input logic [31:0] d);
        if (p) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    // Single-port access; called at a negedge with the DUT idle.
    task automatic do_access(input bit p, input bit w, input logic [4:0] a, input logic [31:0] d);
        drive(p, 1'b1, w, a, d);
        drive(!p, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("gnt0", gnt0, p == 0);
        chk("gnt1", gnt1, p == 1);
        chk("busy_access", busy, 1);
        chk("mem_we", mem_we, w);
        chk("mem_re", mem_re, !w);
        chk("mem_addr", mem_addr, a);
        if (w) chk("mem_wdata", mem_wdata, d);
        drive(p, 1'b0, 1'b0, '0, '0);
        lw = p;
        if (w) ref_mem[a] = d;
        else   exp_rdata = ref_mem[a];
        @(negedge clk);
        chk("done0", done0, p == 0);
        chk("done1", done1, p == 1);
        chk("busy_resp", busy, 1);
        chk("rdata", rdata, exp_rdata);
        @(negedge clk);
        chk("busy_idle", busy, 0);
    endtask

    // Both ports request continuously for n grants; each winner presents a fresh op after its grant.
    task automatic both_phase(input int n);
        bit          pw [2];
        logic [4:0]  pa [2];
        logic [31:0] pd [2];
        bit          w;
        for (int k = 0; k < 2; k++) begin
            pw[k] = 1'($urandom_range(0, 1)); pa[k] = rnd_addr(); pd[k] = $urandom;
            drive(k[0], 1'b1, pw[k], pa[k], pd[k]);
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            w = !lw;
            chk("tie_gnt0", gnt0, w == 0);
            chk("tie_gnt1", gnt1, w == 1);
            chk("tie_addr", mem_addr, pa[w]);
            chk("tie_we", mem_we, pw[w]);
            lw = w;
            if (pw[w]) ref_mem[pa[w]] = pd[w];
            else       exp_rdata = ref_mem[pa[w]];
            pw[w] = 1'($urandom_range(0, 1)); pa[w] = rnd_addr(); pd[w] = $urandom;
            drive(w, 1'b1, pw[w], pa[w], pd[w]);
            @(negedge clk);
            chk("tie_done0", done0, w == 0);
            chk("tie_done1", done1, w == 1);
            chk("tie_rdata", rdata, exp_rdata);
            if (i == n - 1) begin
                req0 = 0; req1 = 0;
            end
            @(negedge clk);
            chk("tie_idle", busy, 0);
        end
    endtask

    initial begin
        int wc;
        logic [31:0] v5;
        for (int i = 0; i < 32; i++) begin
            init_mem[i] = $urandom;
            written[i]  = 1'b0;
        end
        init_mem[3] = 32'hDEADBEEF;
        init_mem[7] = 32'h0;
        for (int i = 0; i < 32; i++) ref_mem[i] = init_mem[i];
        reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;

        // Reset state
        do_reset();
        chk("rst_outs", {29'd0, gnt0, gnt1, done0}, 0);
        chk("rst_done1_busy", {30'd0, done1, busy}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem", {mem_we, mem_re, mem_addr, 25'd0}, 0);
        chk("rst_wdata", mem_wdata, 0);
        do_access(1'b0, 1'b0, 5'd3, 32'h0);
        chk("first_read", rdata, 32'hDEADBEEF);

        // Port 1 write then read of addr 31
        wc = we_cnt;
        do_access(1'b1, 1'b1, 5'd31, 32'h12345678);
        do_access(1'b1, 1'b0, 5'd31, 32'h0);
        chk("wr_rd_31", rdata, 32'h12345678);
        chk("we_cycles", we_cnt - wc, 1);

        // Simultaneous continuous requests from reset: 0,1,0,1,...
        do_reset();
        both_phase(6);

        // Fairness: three port-0 solos, then a tie goes to port 1
        for (int i = 0; i < 3; i++) do_access(1'b0, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
        both_phase(1);

        // Randomized single-port traffic
        for (int i = 0; i < 20; i++) begin
            do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        // Reset during the ACCESS cycle of a write
        drive(1'b1, 1'b1, 1'b1, 5'd7, 32'hAAAA5555);
        @(negedge clk);
        reset = 1'b1;
        req1 = 0;
        #1;
        chk("rst_mid_we", mem_we, 0);
        @(negedge clk);
        reset = 1'b0;
        lw = 1'b1;
        exp_rdata = '0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done1", done1, 0);
        chk("rst_mid_mem7", env_word(5'd7), 0);
        @(negedge clk);
        chk("rst_mid_done1_b", done1, 0);
        do_access(1'b0, 1'b0, 5'd7, 32'h0);

        // Address change after grant must not affect the access
        v5 = ref_mem[5];
        drive(1'b0, 1'b1, 1'b0, 5'd5, 32'h0);
        @(negedge clk);
        addr0 = 5'd9;
        req0 = 0;
        #1;
        chk("stab_gnt0", gnt0, 1);
        chk("stab_addr", mem_addr, 5);
        @(negedge clk);
        chk("stab_done0", done0, 1);
        chk("stab_rdata", rdata, v5);
        @(negedge clk);
        chk("stab_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
